// File: rtl/mod_inv.sv
// mod_inv: modular inverse over GF(2^255-19), binary extended Euclid.
// Define MOD_INV_CYCLE_CNT_EN to add the 12-bit 'cycles' count port.
module mod_inv #(
    parameter int           N = 256,
    parameter logic [N-1:0] P = (256'd1 << 255) - 256'd19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    output logic [N-1:0] result,
    output logic         data_rdy,
    output logic         busy,
    output logic         err
`ifdef MOD_INV_CYCLE_CNT_EN
    ,
    output logic [11:0]  cycles
`endif
);

    localparam logic [N:0] PX = {1'b0, P};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SHIFT_U,
        S_SHIFT_V,
        S_SUB,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] u_q, u_d;
    logic [N-1:0] v_q, v_d;
    logic [N:0]   x1_q, x1_d;
    logic [N:0]   x2_q, x2_d;
    logic [N-1:0] result_q, result_d;
    logic         data_rdy_q, data_rdy_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;

    logic         u_ge_p;
    logic         u_ge_v;
    logic         u_one;
    logic         v_one;
    logic [N:0]   x1_sum;
    logic [N:0]   x2_sum;
    logic [N:0]   x1_half;
    logic [N:0]   x2_half;
    logic [N:0]   d12;
    logic [N:0]   d21;
    logic [N:0]   x1_sub;
    logic [N:0]   x2_sub;

    assign u_ge_p = (u_q >= P);
    assign u_ge_v = (u_q >= v_q);
    assign u_one  = (u_q == N'(1));
    assign v_one  = (v_q == N'(1));

    // Halving mod P: an odd coefficient gets +P first so the shift is exact.
    assign x1_sum  = x1_q + PX;
    assign x2_sum  = x2_q + PX;
    assign x1_half = x1_q[0] ? {1'b0, x1_sum[N:1]} : {1'b0, x1_q[N:1]};
    assign x2_half = x2_q[0] ? {1'b0, x2_sum[N:1]} : {1'b0, x2_q[N:1]};

    // Coefficient subtraction mod P: a borrow is repaired by adding P.
    assign d12    = x1_q - x2_q;
    assign d21    = x2_q - x1_q;
    assign x1_sub = (x1_q >= x2_q) ? d12 : d12 + PX;
    assign x2_sub = (x2_q >= x1_q) ? d21 : d21 + PX;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            u_q        <= '0;
            v_q        <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            result_q   <= '0;
            data_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            v_q        <= v_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            result_q   <= result_d;
            data_rdy_q <= data_rdy_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: one Euclid step (halving or subtraction) per clock.
    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        v_d        = v_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        result_d   = result_q;
        data_rdy_d = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    u_d     = x;
                    busy_d  = 1'b1;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (u_ge_p) begin
                    u_d = u_q - P;
                end else if (u_q == '0) begin
                    result_d   = '0;
                    err_d      = 1'b1;
                    data_rdy_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    v_d     = P;
                    x1_d    = (N+1)'(1);
                    x2_d    = '0;
                    state_d = S_SHIFT_U;
                end
            end
            S_SHIFT_U: begin
                if (u_one || v_one) begin
                    result_d   = u_one ? x1_q[N-1:0] : x2_q[N-1:0];
                    data_rdy_d = 1'b1;
                    state_d    = S_DONE;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (v_q[0]) begin
                    // v is already odd: skip the idle pass through SHIFT_V.
                    state_d = S_SUB;
                end else begin
                    state_d = S_SHIFT_V;
                end
            end
            S_SHIFT_V: begin
                if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                // Only the operand just made even needs halving next.
                if (u_ge_v) begin
                    u_d     = u_q - v_q;
                    x1_d    = x1_sub;
                    state_d = S_SHIFT_U;
                end else begin
                    v_d     = v_q - u_q;
                    x2_d    = x2_sub;
                    state_d = S_SHIFT_V;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign result   = result_q;
    assign data_rdy = data_rdy_q;
    assign busy     = busy_q;
    assign err      = err_q;

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] cycles_q, cycles_d;
    logic [12:0] cnt_fin;

    // The reported count includes the data_rdy cycle about to follow.
    assign cnt_fin = {1'b0, cnt_q} + 13'd2;

    // Busy-cycle counter, saturating; latched alongside data_rdy.
    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
        end else if (busy_q && cnt_q != 12'hFFF) begin
            cnt_d = cnt_q + 12'd1;
        end
        if (data_rdy_d) begin
            cycles_d = cnt_fin[12] ? 12'hFFF : cnt_fin[11:0];
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mod_inv.sv
// tb_mod_inv: directed vector table plus random and corner sequences.
// Checks inverse values, err, handshake timing and reset abort.
module tb_mod_inv;

    localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
    localparam logic [255:0] H2 = (256'd1 << 254) - 256'd9;
    localparam logic [255:0] PM = (256'd1 << 255) - 256'd20;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] x;
    logic [255:0] result;
    logic         data_rdy;
    logic         busy;
    logic         err;
`ifdef MOD_INV_CYCLE_CNT_EN
    logic [11:0]  cycles;
`endif

    int n_chk;
    int n_fail;

    mod_inv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x        (x),
        .result   (result),
        .data_rdy (data_rdy),
        .busy     (busy),
        .err      (err)
`ifdef MOD_INV_CYCLE_CNT_EN
        ,
        .cycles   (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] x;
        logic [255:0] res;
        logic         err;
    } vec_t;

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // a*b mod P by double-and-add; a must be < P.
    function automatic logic [255:0] mulmod(input logic [255:0] a,
                                            input logic [255:0] b);
        logic [256:0] acc;
        acc = '0;
        for (int i = 255; i >= 0; i--) begin
            acc = acc << 1;
            if (acc >= {1'b0, P}) acc = acc - {1'b0, P};
            if (b[i]) begin
                acc = acc + {1'b0, a};
                if (acc >= {1'b0, P}) acc = acc - {1'b0, P};
            end
        end
        return acc[255:0];
    endfunction

    function automatic logic [255:0] rnd_x();
        logic [255:0] r;
        do begin
            for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
            r[255] = 1'b0;
        end while (r == '0 || r >= P);
        return r;
    endfunction

    // Call at a falling edge with the DUT idle; returns one falling edge
    // after the data_rdy cycle (or two when pk_done).
    task automatic do_op(input logic [255:0] xv, input bit pk_busy,
                         input bit pk_done, input string tag,
                         output logic [255:0] res, output logic er,
                         output int n);
        bit to;
        bit bsy_ok;
        start = 1'b1;
        x     = xv;
        @(negedge clk);
        start  = 1'b0;
        x      = '0;
        n      = 0;
        to     = 1'b0;
        bsy_ok = 1'b1;
        forever begin
            n++;
            if (data_rdy) break;
            if (!busy) bsy_ok = 1'b0;
            if (n > 1700) begin
                to = 1'b1;
                break;
            end
            start = pk_busy && (n == 3);
            x     = (n == 3) ? 256'd1 : 256'd0;
            @(negedge clk);
        end
        chk({tag, " timeout"}, to, 0);
        chk({tag, " latency<=1600"}, (n <= 1600), 1);
        chk({tag, " busy during op"}, bsy_ok, 1);
        chk({tag, " busy with data_rdy"}, busy, 1);
        res = result;
        er  = err;
`ifdef MOD_INV_CYCLE_CNT_EN
        chk({tag, " cycles"}, cycles, n);
`endif
        start = pk_done;
        x     = 256'd1;
        @(negedge clk);
        start = 1'b0;
        x     = '0;
        chk({tag, " data_rdy one pulse"}, data_rdy, 0);
        chk({tag, " busy after"}, busy, 0);
        if (pk_done) begin
            @(negedge clk);
            chk({tag, " start in DONE ignored"}, busy, 0);
            chk({tag, " result held"}, result, res);
        end
    endtask

    vec_t         tbl[8];
    logic [255:0] r;
    logic         e;
    int           n;
    int           rdy_seen;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl[0] = '{256'd1,          256'd1, 1'b0};
        tbl[1] = '{256'd2,          H2,     1'b0};
        tbl[2] = '{P + 256'd2,      H2,     1'b0};
        tbl[3] = '{PM,              PM,     1'b0};
        tbl[4] = '{256'd0,          256'd0, 1'b1};
        tbl[5] = '{P,               256'd0, 1'b1};
        tbl[6] = '{P + P,           256'd0, 1'b1};
        tbl[7] = '{256'd3, {128{2'b01}} - 256'd12, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        repeat (3) @(negedge clk);
        chk("reset result", result, 0);
        chk("reset data_rdy", data_rdy, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
`ifdef MOD_INV_CYCLE_CNT_EN
        chk("reset cycles", cycles, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].x, i[0], (i == 0 || i == 4),
                  $sformatf("vec%0d", i), r, e, n);
            chk($sformatf("vec%0d result", i), r, tbl[i].res);
            chk($sformatf("vec%0d err", i), e, tbl[i].err);
        end

        for (int i = 0; i < 24; i++) begin
            logic [255:0] xv;
            xv = rnd_x();
            do_op(xv, 1'b1, i[0], $sformatf("rnd%0d", i), r, e, n);
            chk($sformatf("rnd%0d x*y mod p", i), mulmod(xv, r), 1);
            chk($sformatf("rnd%0d err", i), e, 0);
        end

        start = 1'b1;
        x     = 256'd3;
        @(negedge clk);
        start    = 1'b0;
        x        = '0;
        rdy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (data_rdy) rdy_seen++;
            @(negedge clk);
        end
        chk("mid-op busy before reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset result", result, 0);
        chk("async reset busy", busy, 0);
        chk("async reset data_rdy", data_rdy, 0);
        chk("async reset err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_rdy || busy) rdy_seen++;
        end
        chk("no data_rdy from aborted op", rdy_seen, 0);
        do_op(256'd3, 1'b0, 1'b0, "after reset", r, e, n);
        chk("after reset x=3 result", r, {128{2'b01}} - 256'd12);
        chk("after reset x=3 err", e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
